ncpu32k_ie_lu_pipe: RTL and testbench

Parametrised, pipelined successor to the integer-execute logic/shift unit.
- Executes AND, OR, XOR, LSL, LSR, ASR and the new ROR op.
- Two-stage valid/ready pipeline with full backpressure, a synchronous flush, and an illegal-opcode flag.
- Sits between the IEU issue stage and writeback arbitration; data width is parametrised.

---
 rtl/ncpu32k_ie_lu_pipe.sv | 144 ++++++++++++++
 tb/tb_ncpu32k_ie_lu_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncpu32k_ie_lu_pipe.sv
// Pipelined logic/shift execute unit for the integer pipeline.
//
// Executes AND, OR, XOR, LSL, LSR, ASR and ROR on DW-bit operands with a
// two-stage valid/ready pipeline (S1: operands, S2: result).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                synchronous pipeline kill (drops S1 and S2)
//   in_valid/in_ready    issue-side handshake
//   in_operand_1/2       source A (shift data) / source B (low SAW bits = shift amount)
//   in_opc               one-hot opcode: [0]AND [1]OR [2]XOR [3]LSL [4]LSR [5]ASR [6]ROR
//   out_valid/out_ready  writeback-side handshake
//   out_result           operation result (0 for an illegal opcode)
//   out_err              opcode was illegal
//   out_op_shift         result came from a shift or rotate
module ncpu32k_ie_lu_pipe #(
  parameter int unsigned DW         = 32,
  parameter int unsigned SAW        = 5,
  parameter bit          ENABLE_ASR = 1'b1,
  parameter bit          ENABLE_ROR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_operand_1,
  input  logic [DW-1:0] in_operand_2,
  input  logic [6:0]    in_opc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_err,
  output logic          out_op_shift
);

  // Stage 1 registers
  logic          s1_valid;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [6:0]    s1_opc;

  // Stage 2 registers
  logic          s2_valid;
  logic [DW-1:0] s2_result;
  logic          s2_err;
  logic          s2_op_shift;

  logic s2_adv;
  logic accept;

  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~rst & (~s1_valid | s2_adv);
  assign accept   = in_valid & in_ready & ~flush;

  // Compute between S1 and S2
  logic [SAW-1:0] sh;
  logic [DW-1:0]  a_rev;
  logic [DW-1:0]  sh_data;
  logic [DW-1:0]  sh_fill;
  logic [DW-1:0]  sh_out;
  logic [DW-1:0]  sh_out_rev;
  logic           legal;
  logic [DW-1:0]  res;

  always_comb begin
    sh = s1_b[SAW-1:0];
    a_rev = '0;
    for (int i = 0; i < int'(DW); i++) begin
      a_rev[i] = s1_a[int'(DW) - 1 - i];
    end

    // One right barrel shifter over a {fill, data} window serves every shift:
    // LSL shifts the bit-reversed operand right and reverses the result back,
    // ASR fills with sign bits, ROR fills with the operand itself.
    sh_data = s1_opc[3] ? a_rev : s1_a;
    sh_fill = '0;
    if (s1_opc[5] && ENABLE_ASR) sh_fill = {DW{s1_a[DW-1]}};
    if (s1_opc[6]) sh_fill = s1_a;
    sh_out = DW'({sh_fill, sh_data} >> sh);

    sh_out_rev = '0;
    for (int i = 0; i < int'(DW); i++) begin
      sh_out_rev[i] = sh_out[int'(DW) - 1 - i];
    end

    legal = $onehot(s1_opc) && !(s1_opc[6] && !ENABLE_ROR);

    res = '0;
    if (legal) begin
      unique case (s1_opc)
        7'b0000001: res = s1_a & s1_b;
        7'b0000010: res = s1_a | s1_b;
        7'b0000100: res = s1_a ^ s1_b;
        7'b0001000: res = sh_out_rev;
        7'b0010000: res = sh_out;
        7'b0100000: res = sh_out;
        7'b1000000: res = sh_out;
        default:    res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_opc      <= '0;
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_err      <= 1'b0;
      s2_op_shift <= 1'b0;
    end else if (flush) begin
      // Data registers are left as they are; only the valid bits die.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_operand_1;
        s1_b     <= in_operand_2;
        s1_opc   <= in_opc;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        s2_valid    <= 1'b1;
        s2_result   <= res;
        s2_err      <= ~legal;
        s2_op_shift <= legal & (|s1_opc[6:3]);
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_result   = s2_result;
  assign out_err      = s2_err;
  assign out_op_shift = s2_op_shift;

endmodule

// File: tb/tb_ncpu32k_ie_lu_pipe.sv
// Directed self-checking bench for ncpu32k_ie_lu_pipe (DW=32).
module tb_ncpu32k_ie_lu_pipe;

  localparam logic [6:0] OP_AND = 7'b0000001;
  localparam logic [6:0] OP_OR  = 7'b0000010;
  localparam logic [6:0] OP_XOR = 7'b0000100;
  localparam logic [6:0] OP_LSL = 7'b0001000;
  localparam logic [6:0] OP_LSR = 7'b0010000;
  localparam logic [6:0] OP_ASR = 7'b0100000;
  localparam logic [6:0] OP_ROR = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_operand_1;
  logic [31:0] in_operand_2;
  logic [6:0]  in_opc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic        out_op_shift;

  int pass_cnt = 0;
  int total_cnt = 0;

  ncpu32k_ie_lu_pipe #(
    .DW        (32),
    .SAW       (5),
    .ENABLE_ASR(1'b1),
    .ENABLE_ROR(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operand_1(in_operand_1),
    .in_operand_2(in_operand_2),
    .in_opc      (in_opc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_err     (out_err),
    .out_op_shift(out_op_shift)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid     = v;
    in_opc       = opc;
    in_operand_1 = a;
    in_operand_2 = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    tick(); tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_result !== 32'd0) $display("FAIL reset_result: got %h want 0", out_result);
    else pass_cnt++;
    total_cnt++;
    if (out_err !== 1'b0 || out_op_shift !== 1'b0)
      $display("FAIL reset_flags: got err=%b sh=%b want 0 0", out_err, out_op_shift);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    logic [6:0]  ops [3];
    exp[0] = 32'h00F0_000F; exp[1] = 32'hFFF0_0FFF; exp[2] = 32'hFF00_0FF0;
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 32'hF0F0_00FF, 32'h0FF0_0F0F);
      tick();
      if (i == 0) begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_latency: got valid=%b want 0", out_valid);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== exp[i-1])
          $display("FAIL b2b_op%0d: got v=%b %h want v=1 %h", i - 1, out_valid, out_result,
                   exp[i-1]);
        else pass_cnt++;
      end
    end
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== exp[2] || out_err !== 1'b0 || out_op_shift !== 1'b0)
      $display("FAIL b2b_op2: got v=%b %h err=%b sh=%b want v=1 %h err=0 sh=0", out_valid,
               out_result, out_err, out_op_shift, exp[2]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: got valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_shifts();
    logic [6:0]  ops [6];
    logic [31:0] bs  [6];
    logic [31:0] exp [6];
    ops[0] = OP_LSL; bs[0] = 32'd4;  exp[0] = 32'h0000_0010;
    ops[1] = OP_LSR; bs[1] = 32'd31; exp[1] = 32'h0000_0001;
    ops[2] = OP_ASR; bs[2] = 32'd31; exp[2] = 32'hFFFF_FFFF;
    ops[3] = OP_ROR; bs[3] = 32'd1;  exp[3] = 32'hC000_0000;
    ops[4] = OP_ROR; bs[4] = 32'h20; exp[4] = 32'h8000_0001;
    ops[5] = OP_LSL; bs[5] = 32'h20; exp[5] = 32'h8000_0001;
    out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1'b1, ops[i], 32'h8000_0001, bs[i]);
      else drive(1'b0, 7'd0, 32'd0, 32'd0);
      tick();
      if (i > 0) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== exp[i-1] || out_op_shift !== 1'b1 ||
            out_err !== 1'b0)
          $display("FAIL shift%0d: got v=%b %h sh=%b err=%b want v=1 %h sh=1 err=0", i - 1,
                   out_valid, out_result, out_op_shift, out_err, exp[i-1]);
        else pass_cnt++;
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, OP_AND, 32'd1, 32'hFFFF_FFFF);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_accept0: got in_ready=%b want 1", in_ready);
    else pass_cnt++;
    tick();
    drive(1'b1, OP_AND, 32'd2, 32'hFFFF_FFFF);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_accept1: got in_ready=%b want 1", in_ready);
    else pass_cnt++;
    tick();
    drive(1'b1, OP_AND, 32'd3, 32'hFFFF_FFFF);
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd1)
        $display("FAIL bp_stall%0d: got rdy=%b v=%b %h want rdy=0 v=1 00000001", c, in_ready,
                 out_valid, out_result);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    drive(1'b1, OP_AND, 32'd4, 32'hFFFF_FFFF);
    for (int k = 2; k <= 4; k++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_result !== 32'(k))
        $display("FAIL bp_order%0d: got v=%b %h want v=1 %h", k, out_valid, out_result, 32'(k));
      else pass_cnt++;
      if (k == 2) tick();
      else begin
        drive(1'b0, 7'd0, 32'd0, 32'd0);
        tick();
      end
    end
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 7'b0000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 7'b0001001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_err !== 1'b1 || out_op_shift !== 1'b0)
      $display("FAIL illegal_zero: got v=%b %h err=%b sh=%b want v=1 0 err=1 sh=0", out_valid,
               out_result, out_err, out_op_shift);
    else pass_cnt++;
    drive(1'b1, OP_XOR, 32'd5, 32'd3);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_err !== 1'b1 || out_op_shift !== 1'b0)
      $display("FAIL illegal_multi: got v=%b %h err=%b sh=%b want v=1 0 err=1 sh=0", out_valid,
               out_result, out_err, out_op_shift);
    else pass_cnt++;
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 32'd6 || out_err !== 1'b0)
      $display("FAIL illegal_recover: got v=%b %h err=%b want v=1 00000006 err=0", out_valid,
               out_result, out_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, OP_AND, 32'h11, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, OP_AND, 32'h22, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, OP_AND, 32'h33, 32'hFFFF_FFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_kill: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_accept: got valid=%b want 0", out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    drive(1'b1, OP_OR, 32'h40, 32'h04);
    tick();
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 32'h44)
      $display("FAIL flush_after: got v=%b %h want v=1 00000044", out_valid, out_result);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(1'b1, OP_ASR, 32'h8000_0000, 32'd4);
    tick();
    drive(1'b1, OP_ROR, 32'h0000_00F0, 32'd4);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 32'hF800_0000 || out_op_shift !== 1'b1)
      $display("FAIL rst_stall_pre: got v=%b %h sh=%b want v=1 f8000000 sh=1", out_valid,
               out_result, out_op_shift);
    else pass_cnt++;
    rst = 1'b1;
    drive(1'b1, OP_AND, 32'h55, 32'hFFFF_FFFF);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL rst_stall_ready: got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_err !== 1'b0 || out_op_shift !== 1'b0)
      $display("FAIL rst_stall_clear: got v=%b %h err=%b sh=%b want all 0", out_valid,
               out_result, out_err, out_op_shift);
    else pass_cnt++;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 7'd0, 32'd0, 32'd0);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_stall_ready_after: got %b want 1", in_ready);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL rst_stall_stale%0d: got valid=%b want 0", c,
                                       out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shifts();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
